// File: rtl/btn_reset_conditioner.sv
// Button conditioning for the system core: sync, debounce, reset sequencing, one-shot NMI and SD LED.
// Define LED_STRETCH_EN to stretch SD activity on SDLED; otherwise SDLED is ~SD_ACT combinationally.
module btn_reset_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned POR_CYCLES        = 5000000,
    parameter int unsigned RESET_HOLD_CYCLES = 50000,
    parameter int unsigned NMI_PULSE_CYCLES  = 16,
    parameter int unsigned LED_HOLD_CYCLES   = 2500000
) (
    input  logic CLK_50MHZ,
    input  logic RST,
    input  logic BTN_SOUTH,
    input  logic BTN_WEST,
    input  logic SD_ACT,
    output logic BTN_RESET,
    output logic BTN_NMI,
    output logic SDLED
);

    localparam int unsigned RC_MAX = (POR_CYCLES > RESET_HOLD_CYCLES) ? POR_CYCLES : RESET_HOLD_CYCLES;
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RC_W = $clog2(RC_MAX + 1);
    localparam int NC_W = $clog2(NMI_PULSE_CYCLES + 1);

    // state     | meaning
    // R_POR     | power-on stretch after RST release
    // R_RUN     | system running, BTN_RESET low
    // R_HELD    | reset button held down
    // R_STRETCH | extra hold time after release
    // N_IDLE    | armed for a west press
    // N_PULSE   | driving BTN_NMI
    // N_WAIT_REL| waiting for west release
    typedef enum logic [1:0] {R_POR, R_RUN, R_HELD, R_STRETCH} rst_state_t;
    typedef enum logic [1:0] {N_IDLE, N_PULSE, N_WAIT_REL} nmi_state_t;

    logic [1:0]      raw, sync1, sync2, deb;
    logic [DB_W-1:0] deb_cnt [2];

    rst_state_t      r_state, r_next;
    nmi_state_t      n_state, n_next;
    logic [RC_W-1:0] rc, rc_next, rc_inc;
    logic [NC_W-1:0] nc, nc_next, nc_inc;
    logic            por_seen, por_seen_next;
    logic            west_prev;
    logic            south_pressed, west_pressed, west_press_edge, leaving_run;

    assign raw = {BTN_WEST, BTN_SOUTH};

    // Index 0 is the reset button, index 1 the NMI button; both idle high.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            sync1      <= '1;
            sync2      <= '1;
            deb        <= '1;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i]     <= ~deb[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign south_pressed   = ~deb[0];
    assign west_pressed    = ~deb[1];
    assign west_press_edge = west_prev & ~deb[1];
    assign rc_inc          = (rc == RC_W'(RC_MAX)) ? rc : rc + 1'b1;
    assign nc_inc          = (nc == NC_W'(NMI_PULSE_CYCLES)) ? nc : nc + 1'b1;

    always_comb begin
        r_next        = r_state;
        rc_next       = rc;
        por_seen_next = por_seen;
        case (r_state)
            R_POR: begin
                if (south_pressed) por_seen_next = 1'b1;
                if (rc == RC_W'(POR_CYCLES - 1)) begin
                    r_next  = (por_seen || south_pressed) ? R_HELD : R_RUN;
                    rc_next = '0;
                end else begin
                    rc_next = rc_inc;
                end
            end
            R_RUN: begin
                if (south_pressed) r_next = R_HELD;
            end
            R_HELD: begin
                if (!south_pressed) begin
                    r_next  = R_STRETCH;
                    rc_next = '0;
                end
            end
            R_STRETCH: begin
                if (south_pressed) begin
                    r_next  = R_HELD;
                    rc_next = '0;
                end else if (rc == RC_W'(RESET_HOLD_CYCLES - 1)) begin
                    r_next  = R_RUN;
                    rc_next = '0;
                end else begin
                    rc_next = rc_inc;
                end
            end
            default: r_next = R_POR;
        endcase
    end

    // Reset wins: dropping out of RUN cancels any pulse and needs a fresh west press.
    assign leaving_run = (r_state == R_RUN) && (r_next != R_RUN);

    always_comb begin
        n_next  = n_state;
        nc_next = nc;
        if (leaving_run) begin
            n_next  = N_WAIT_REL;
            nc_next = '0;
        end else begin
            case (n_state)
                N_IDLE: begin
                    if (west_press_edge && (r_state == R_RUN)) begin
                        n_next  = N_PULSE;
                        nc_next = '0;
                    end
                end
                N_PULSE: begin
                    if (nc == NC_W'(NMI_PULSE_CYCLES - 1)) begin
                        n_next  = N_WAIT_REL;
                        nc_next = '0;
                    end else begin
                        nc_next = nc_inc;
                    end
                end
                N_WAIT_REL: begin
                    if (!west_pressed) n_next = N_IDLE;
                end
                default: n_next = N_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            r_state   <= R_POR;
            n_state   <= N_IDLE;
            rc        <= '0;
            nc        <= '0;
            por_seen  <= 1'b0;
            west_prev <= 1'b1;
            BTN_RESET <= 1'b1;
            BTN_NMI   <= 1'b0;
        end else begin
            r_state   <= r_next;
            n_state   <= n_next;
            rc        <= rc_next;
            nc        <= nc_next;
            por_seen  <= por_seen_next;
            west_prev <= deb[1];
            BTN_RESET <= (r_next != R_RUN);
            BTN_NMI   <= (n_next == N_PULSE);
        end
    end

`ifdef LED_STRETCH_EN
    localparam int LH_W = $clog2(LED_HOLD_CYCLES + 1);
    logic [LH_W-1:0] led_cnt;

    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            led_cnt <= '0;
            SDLED   <= 1'b1;
        end else if (SD_ACT) begin
            led_cnt <= LH_W'(LED_HOLD_CYCLES);
            SDLED   <= 1'b0;
        end else if (led_cnt != '0) begin
            led_cnt <= led_cnt - 1'b1;
            SDLED   <= 1'b0;
        end else begin
            SDLED   <= 1'b1;
        end
    end
`else
    assign SDLED = ~SD_ACT;

    // The hold time only matters when stretching is built in.
    if (LED_HOLD_CYCLES == 0) begin : g_led_hold_unused
    end
`endif

endmodule

// File: tb/tb_btn_reset_conditioner.sv
// Randomized and directed bench for btn_reset_conditioner against a timestamp-based behavioural model.
module tb_btn_reset_conditioner;

    localparam int D   = 8;
    localparam int POR = 20;
    localparam int H   = 10;
    localparam int P   = 4;
    localparam int LH  = 16;

    logic CLK_50MHZ, RST, BTN_SOUTH, BTN_WEST, SD_ACT;
    logic BTN_RESET, BTN_NMI, SDLED;

    int tests  = 0;
    int failed = 0;

    btn_reset_conditioner #(
        .DEBOUNCE_CYCLES(D), .POR_CYCLES(POR), .RESET_HOLD_CYCLES(H),
        .NMI_PULSE_CYCLES(P), .LED_HOLD_CYCLES(LH)
    ) dut (
        .CLK_50MHZ(CLK_50MHZ), .RST(RST), .BTN_SOUTH(BTN_SOUTH), .BTN_WEST(BTN_WEST),
        .SD_ACT(SD_ACT), .BTN_RESET(BTN_RESET), .BTN_NMI(BTN_NMI), .SDLED(SDLED)
    );

    initial begin
        CLK_50MHZ = 1'b0;
        forever #5 CLK_50MHZ = ~CLK_50MHZ;
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0b, expected %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Modes: 0 power-on, 1 running, 2 held, 3 stretching. NMI: 0 armed, 1 pulsing, 2 waiting release.
    bit hs_s[$], hs_w[$];     // raw samples per clock edge, oldest first
    int n;                    // edges since RST release
    bit md_s, md_w;           // model debounced levels
    int rmode, nmode, st_start, p_start, w_press_time, last_sd;
    bit por_pressed;
    bit exp_rst, exp_nmi, exp_led;

    // A debounced level flips once the synchroniser has shown the other level for D edges in a row;
    // the debouncer at edge n sees the raw sample taken at edge n-2.
    function automatic bit all_differ(input bit q[$], input bit d);
        for (int i = 2; i <= D + 1; i++)
            if (q[q.size() - i] == d) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        hs_s.delete();
        hs_w.delete();
        for (int i = 0; i < D + 2; i++) begin
            hs_s.push_back(1'b1);
            hs_w.push_back(1'b1);
        end
        n = 0; md_s = 1'b1; md_w = 1'b1; rmode = 0; nmode = 0; por_pressed = 1'b0;
        w_press_time = -100; last_sd = -1000;
        exp_rst = 1'b1; exp_nmi = 1'b0;
`ifdef LED_STRETCH_EN
        exp_led = 1'b1;
`else
        exp_led = ~SD_ACT;
`endif
    endtask

    task automatic model_step();
        int new_r;
        bit press_edge;
        n++;
        new_r = rmode;
        case (rmode)
            0: begin
                if (!md_s) por_pressed = 1'b1;
                if (n == POR) new_r = por_pressed ? 2 : 1;
            end
            1: if (!md_s) new_r = 2;
            2: if (md_s) begin new_r = 3; st_start = n; end
            default: begin
                if (!md_s) new_r = 2;
                else if (n - st_start == H) new_r = 1;
            end
        endcase
        press_edge = (w_press_time == n - 1);
        if (rmode == 1 && new_r != 1) nmode = 2;
        else case (nmode)
            0: if (press_edge && rmode == 1) begin nmode = 1; p_start = n; end
            1: if (n - p_start == P) nmode = 2;
            default: if (md_w) nmode = 0;
        endcase
        rmode = new_r;
        if (all_differ(hs_s, md_s)) md_s = ~md_s;
        if (all_differ(hs_w, md_w)) begin
            md_w = ~md_w;
            if (!md_w) w_press_time = n;
        end
        hs_s.push_back(BTN_SOUTH);
        hs_w.push_back(BTN_WEST);
        while (hs_s.size() > D + 3) begin
            void'(hs_s.pop_front());
            void'(hs_w.pop_front());
        end
        if (SD_ACT) last_sd = n;
        exp_rst = (rmode != 1);
        exp_nmi = (nmode == 1);
`ifdef LED_STRETCH_EN
        exp_led = !(n - last_sd <= LH);
`else
        exp_led = ~SD_ACT;
`endif
    endtask

    always @(posedge CLK_50MHZ) begin
        #1;
        if (RST) model_reset();
        else model_step();
        check_bit("btn_reset", BTN_RESET, exp_rst);
        check_bit("btn_nmi", BTN_NMI, exp_nmi);
        check_bit("sdled", SDLED, exp_led);
    end

    // ---------------- stimulus and measurements ----------------
    int idx, first_hi, first_low, first_fall, first_nmi, nmi_hi, led_lo;

    task automatic clr();
        idx = 0; first_hi = -1; first_low = -1; first_fall = -1; first_nmi = -1;
        nmi_hi = 0; led_lo = 0;
    endtask

    // Called at a falling edge; drives inputs, samples after each rising edge.
    task automatic run(input logic s, input logic w, input logic a, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            BTN_SOUTH = s; BTN_WEST = w; SD_ACT = a;
            @(posedge CLK_50MHZ);
            #1;
            idx++;
            if (BTN_RESET === 1'b1 && first_hi < 0) first_hi = idx;
            if (BTN_RESET === 1'b0 && first_low < 0) first_low = idx;
            if (BTN_RESET === 1'b0 && first_hi >= 0 && first_fall < 0) first_fall = idx;
            if (BTN_NMI === 1'b1) begin
                nmi_hi++;
                if (first_nmi < 0) first_nmi = idx;
            end
            if (SDLED === 1'b0) led_lo++;
            @(negedge CLK_50MHZ);
        end
    endtask

    task automatic async_rst();
        #2 RST = 1'b1;
        #1;
        check_bit("rst_async_btn_reset", BTN_RESET, 1'b1);
        check_bit("rst_async_btn_nmi", BTN_NMI, 1'b0);
`ifdef LED_STRETCH_EN
        check_bit("rst_async_sdled", SDLED, 1'b1);
`endif
        @(negedge CLK_50MHZ);
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; BTN_SOUTH = 1'b1; BTN_WEST = 1'b1; SD_ACT = 1'b0;
        repeat (3) @(negedge CLK_50MHZ);

        RST = 1'b0;
        clr(); run(1, 1, 0, 25);
        check_int("por_first_low", first_low, 20);
        check_int("por_nmi", nmi_hi, 0);

        clr(); run(0, 1, 0, 30); run(1, 1, 0, 40);
        check_int("south_rise", first_hi, 11);
        check_int("south_fall", first_fall, 51);

        clr(); run(1, 0, 0, 5); run(1, 1, 0, 20);
        check_int("west_glitch_nmi", nmi_hi, 0);

        clr(); run(1, 0, 0, 40); run(1, 1, 0, 20);
        check_int("west_hold_nmi_len", nmi_hi, 4);
        check_int("west_hold_nmi_start", first_nmi, 11);

        clr(); run(0, 0, 0, 30);
        check_int("both_rise", first_hi, 11);
        run(1, 1, 0, 40);
        check_int("both_nmi", nmi_hi, 0);
        clr(); run(1, 0, 0, 30); run(1, 1, 0, 15);
        check_int("repress_nmi", nmi_hi, 4);

        clr(); run(1, 1, 1, 1); run(1, 1, 0, 25);
`ifdef LED_STRETCH_EN
        check_int("led_stretch", led_lo, 17);
`else
        check_int("led_direct", led_lo, 1);
`endif

        clr(); run(0, 1, 0, 30); run(1, 1, 0, 12);
        check_bit("in_stretch", BTN_RESET, 1'b1);
        async_rst();
        clr(); run(1, 1, 0, 25);
        check_int("por_after_stretch_rst", first_low, 20);

        clr(); run(1, 0, 0, 12);
        check_bit("in_pulse", BTN_NMI, 1'b1);
        async_rst();
        clr(); run(1, 1, 0, 25);
        check_int("por_after_pulse_rst", first_low, 20);
        check_int("no_nmi_after_pulse_rst", nmi_hi, 0);

        for (int seg = 0; seg < 200; seg++) begin
            logic s, w;
            int len;
            s = ($urandom_range(0, 2) != 0);
            w = ($urandom_range(0, 2) != 0);
            len = $urandom_range(1, 25);
            for (int c = 0; c < len; c++)
                run(s, w, ($urandom_range(0, 7) == 0), 1);
            if (seg % 37 == 36) async_rst();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
